// File: rtl/melody_pkg.sv
// Shared definitions for the melody sequencer: note codes, the half-period
// table, ROM entry layout and FSM state encoding.
package melody_pkg;

  localparam int NOTE_W  = 4;
  localparam int DUR_W   = 3;
  localparam int ENTRY_W = 1 + NOTE_W + DUR_W;
  localparam int PER_W   = 10;
  localparam int SONG_W  = 2;
  localparam int ADDR_W  = 6;

  localparam logic [NOTE_W-1:0] NOTE_C    = 4'd0;
  localparam logic [NOTE_W-1:0] NOTE_D    = 4'd1;
  localparam logic [NOTE_W-1:0] NOTE_DS   = 4'd2;
  localparam logic [NOTE_W-1:0] NOTE_E    = 4'd3;
  localparam logic [NOTE_W-1:0] NOTE_F    = 4'd4;
  localparam logic [NOTE_W-1:0] NOTE_G    = 4'd5;
  localparam logic [NOTE_W-1:0] NOTE_A    = 4'd6;
  localparam logic [NOTE_W-1:0] NOTE_B    = 4'd7;
  localparam logic [NOTE_W-1:0] NOTE_REST = 4'hE;
  localparam logic [NOTE_W-1:0] NOTE_END  = 4'hF;

  // Half-period counts for the base octave, indexed by note code 0..7
  localparam logic [PER_W-1:0] HALF_PER_TAB [0:7] = '{
    10'd478, 10'd424, 10'd401, 10'd378, 10'd358, 10'd320, 10'd284, 10'd254
  };

  typedef struct packed {
    logic              oct_up;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP,
    ST_DONE
  } state_t;

  function automatic entry_t mk_entry(input logic oct_up, input logic [NOTE_W-1:0] note,
                                      input logic [DUR_W-1:0] dur);
    entry_t e;
    e.oct_up = oct_up;
    e.note   = note;
    e.dur    = dur;
    return e;
  endfunction

  // Codes above NOTE_B (8..14) play as silence; the octave flag halves the count
  function automatic logic [PER_W-1:0] note_period(input entry_t e);
    logic [PER_W-1:0] p;
    if (e.note > NOTE_B) begin
      p = '0;
    end else begin
      p = HALF_PER_TAB[e.note[2:0]];
      if (e.oct_up) p = p >> 1;
    end
    return p;
  endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// Control and status bundle between the game logic and the melody sequencer.
interface melody_sequencer_if;
  import melody_pkg::*;

  logic              start;
  logic              stop;
  logic [SONG_W-1:0] song_sel;
  logic              loop_en;
  logic [PER_W-1:0]  tone_half_per;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] step_addr;

  modport master (
    output start, stop, song_sel, loop_en,
    input  tone_half_per, busy, done, step_addr
  );

  modport slave (
    input  start, stop, song_sel, loop_en,
    output tone_half_per, busy, done, step_addr
  );
endinterface

// File: rtl/melody_sequencer_rom.sv
// Melody ROM for all game sounds, addressed by {song, step}. Unlisted
// locations read as the end marker so a song can never run into the next.
module melody_rom
  import melody_pkg::*;
(
  input  logic                     clk3,
  input  logic [SONG_W+ADDR_W-1:0] addr,
  output entry_t                   data
);

  // Synchronous read from the constant song table
  always_ff @(posedge clk3) begin
    case (addr)
      // song 0: background
      {2'd0, 6'd0}: data <= mk_entry(1'b0, NOTE_C, 3'd0);
      {2'd0, 6'd1}: data <= mk_entry(1'b0, NOTE_E, 3'd0);
      {2'd0, 6'd2}: data <= mk_entry(1'b0, NOTE_G, 3'd0);
      // song 1: success
      {2'd1, 6'd0}: data <= mk_entry(1'b0, NOTE_A, 3'd1);
      {2'd1, 6'd1}: data <= mk_entry(1'b1, NOTE_B, 3'd0);
      {2'd1, 6'd2}: data <= mk_entry(1'b0, NOTE_REST, 3'd2);
      {2'd1, 6'd3}: data <= mk_entry(1'b0, 4'd9, 3'd0);
      // song 2: game over
      {2'd2, 6'd0}: data <= mk_entry(1'b1, NOTE_C, 3'd1);
      {2'd2, 6'd1}: data <= mk_entry(1'b0, NOTE_D, 3'd0);
      {2'd2, 6'd2}: data <= mk_entry(1'b0, NOTE_DS, 3'd0);
      {2'd2, 6'd3}: data <= mk_entry(1'b0, NOTE_F, 3'd0);
      // song 3: time over
      {2'd3, 6'd0}: data <= mk_entry(1'b0, NOTE_B, 3'd0);
      default:      data <= mk_entry(1'b0, NOTE_END, 3'd0);
    endcase
  end

endmodule

// File: rtl/melody_sequencer.sv
// Melody sequencer: walks the selected song in the ROM and drives the tone
// generator's half-period count, one note (plus optional gap) at a time.
//
// state | meaning
// IDLE  | silent, waiting for start
// LOAD  | ROM entry arriving; decode it or handle the end marker
// PLAY  | tone held for (dur+1) beat steps
// GAP   | one silent articulation step after a sounding note
// DONE  | one-cycle done pulse, then IDLE
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int STEP_CYCLES = 62500,
  parameter int ROM_DEPTH   = 64,
  parameter bit GAP_EN      = 1'b1
) (
  input logic               clk3,
  input logic               rst,
  melody_sequencer_if.slave bus
);

  localparam int                STEP_W    = $clog2(STEP_CYCLES);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(ROM_DEPTH - 1);

  state_t                     state;
  logic [SONG_W-1:0]          song_q;
  logic [ADDR_W-1:0]          addr_q;
  logic                       wrap_q;
  logic [STEP_W-1:0]          step_cnt;
  logic [DUR_W-1:0]           dur_left;
  logic                       gap_q;
  logic [PER_W-1:0]           tone_q;
  logic                       busy_q;
  logic                       done_q;
  logic [SONG_W+ADDR_W-1:0]   rom_addr;
  entry_t                     rom_data;

  logic              start_go;
  logic              step_last;
  logic              play_exit;
  logic              gap_exit;
  logic              at_last;
  logic [ADDR_W-1:0] addr_inc;
  logic              is_end;
  logic              is_rest;

  assign start_go  = bus.start && !bus.stop;
  assign step_last = (step_cnt == STEP_LAST);
  assign play_exit = (state == ST_PLAY) && step_last && (dur_left == '0);
  assign gap_exit  = (state == ST_GAP) && step_last;
  assign at_last   = (addr_q == ADDR_LAST);
  assign addr_inc  = at_last ? '0 : addr_q + 1'b1;
  // Stepping past the last slot counts as an end marker, whatever slot 0 holds
  assign is_end    = (rom_data.note == NOTE_END) || wrap_q;
  assign is_rest   = (rom_data.note > NOTE_B);

  // ROM address follows the address being entered so the entry is ready during LOAD
  always_comb begin
    rom_addr = {song_q, addr_q};
    if (start_go) begin
      rom_addr = {bus.song_sel, {ADDR_W{1'b0}}};
    end else if (state == ST_LOAD) begin
      rom_addr = {song_q, {ADDR_W{1'b0}}};
    end else if (play_exit || gap_exit) begin
      rom_addr = {song_q, addr_inc};
    end
  end

  melody_rom u_rom (
    .clk3 (clk3),
    .addr (rom_addr),
    .data (rom_data)
  );

  // Sequencing FSM with step/duration counters and registered outputs
  always_ff @(posedge clk3 or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      song_q   <= '0;
      addr_q   <= '0;
      wrap_q   <= 1'b0;
      step_cnt <= '0;
      dur_left <= '0;
      gap_q    <= 1'b0;
      tone_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.stop) begin
      state    <= ST_IDLE;
      step_cnt <= '0;
      tone_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.start) begin
      state    <= ST_LOAD;
      song_q   <= bus.song_sel;
      addr_q   <= '0;
      wrap_q   <= 1'b0;
      step_cnt <= '0;
      tone_q   <= '0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
        end
        ST_LOAD: begin
          step_cnt <= '0;
          if (is_end) begin
            if (bus.loop_en) begin
              state  <= ST_LOAD;
              addr_q <= '0;
              wrap_q <= 1'b0;
            end else begin
              state  <= ST_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end else begin
            state    <= ST_PLAY;
            tone_q   <= note_period(rom_data);
            dur_left <= rom_data.dur;
            gap_q    <= GAP_EN && !is_rest;
          end
        end
        ST_PLAY: begin
          if (step_last) begin
            step_cnt <= '0;
            if (dur_left == '0) begin
              tone_q <= '0;
              if (gap_q) begin
                state <= ST_GAP;
              end else begin
                state  <= ST_LOAD;
                addr_q <= addr_inc;
                wrap_q <= at_last;
              end
            end else begin
              dur_left <= dur_left - 1'b1;
            end
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (step_last) begin
            step_cnt <= '0;
            state    <= ST_LOAD;
            addr_q   <= addr_inc;
            wrap_q   <= at_last;
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          tone_q <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tone_half_per = tone_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.step_addr     = addr_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with a 4-cycle beat step.
module tb_melody_sequencer;
  import melody_pkg::*;

  logic clk3 = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  melody_sequencer_if bus ();

  melody_sequencer #(
    .STEP_CYCLES (4),
    .ROM_DEPTH   (64),
    .GAP_EN      (1'b1)
  ) dut (
    .clk3 (clk3),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clk3 = ~clk3;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk3);
    #1;
  endtask

  // Check n consecutive cycles of tone/busy with no done pulse
  task automatic run(input string tag, input int n, input int tone, input int busy);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_tone"}, int'(bus.tone_half_per), tone);
      chk({tag, "_busy"}, int'(bus.busy), busy);
      chk({tag, "_done"}, int'(bus.done), 0);
      tick();
    end
  endtask

  task automatic pulse_start(input logic [1:0] sel);
    bus.song_sel = sel;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.song_sel = 2'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.song_sel = 2'd0;
    bus.loop_en  = 1'b0;
    #2;
    chk("rst_tone", int'(bus.tone_half_per), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_addr", int'(bus.step_addr), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    run("idle0", 3, 0, 0);

    // Song 1: A dur1, octave B, rest dur2, code 9 as rest, end without loop
    pulse_start(2'd1);
    chk("s1_addr0", int'(bus.step_addr), 0);
    run("s1_load0", 1, 0, 1);
    run("s1_a", 8, 284, 1);
    run("s1_gap0", 4, 0, 1);
    chk("s1_addr1", int'(bus.step_addr), 1);
    run("s1_load1", 1, 0, 1);
    run("s1_octb", 4, 127, 1);
    run("s1_gap1", 4, 0, 1);
    chk("s1_addr2", int'(bus.step_addr), 2);
    run("s1_load2", 1, 0, 1);
    run("s1_rest", 12, 0, 1);
    chk("s1_addr3", int'(bus.step_addr), 3);
    run("s1_load3", 1, 0, 1);
    run("s1_rest9", 4, 0, 1);
    chk("s1_addr4", int'(bus.step_addr), 4);
    run("s1_load4", 1, 0, 1);
    chk("s1_done_pulse", int'(bus.done), 1);
    chk("s1_done_busy", int'(bus.busy), 0);
    chk("s1_done_tone", int'(bus.tone_half_per), 0);
    tick();
    run("s1_idle", 5, 0, 0);

    // Song 0 with loop: C E G then end marker returns to address 0
    bus.loop_en = 1'b1;
    pulse_start(2'd0);
    run("s0_load0", 1, 0, 1);
    run("s0_c", 4, 478, 1);
    run("s0_gap0", 4, 0, 1);
    chk("s0_addr1", int'(bus.step_addr), 1);
    run("s0_load1", 1, 0, 1);
    run("s0_e", 4, 378, 1);
    run("s0_gap1", 4, 0, 1);
    chk("s0_addr2", int'(bus.step_addr), 2);
    run("s0_load2", 1, 0, 1);
    run("s0_g", 4, 320, 1);
    run("s0_gap2", 4, 0, 1);
    chk("s0_addr3", int'(bus.step_addr), 3);
    run("s0_end_load", 1, 0, 1);
    chk("s0_loop_addr", int'(bus.step_addr), 0);
    run("s0_loop_load", 1, 0, 1);
    run("s0_c_again", 2, 478, 1);

    // Stop in PLAY: silent and idle next cycle, no done
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    bus.loop_en = 1'b0;
    run("stop_idle", 4, 0, 0);

    // Restart with song 2 while song 0 plays
    pulse_start(2'd0);
    run("rs_load0", 1, 0, 1);
    run("rs_c", 2, 478, 1);
    pulse_start(2'd2);
    chk("s2_addr0", int'(bus.step_addr), 0);
    run("s2_load0", 1, 0, 1);
    run("s2_oct_c", 8, 239, 1);
    run("s2_gap0", 4, 0, 1);
    chk("s2_addr1", int'(bus.step_addr), 1);
    run("s2_load1", 1, 0, 1);
    run("s2_d", 4, 424, 1);

    // start and stop together: stop wins
    bus.start    = 1'b1;
    bus.stop     = 1'b1;
    bus.song_sel = 2'd3;
    tick();
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.song_sel = 2'd0;
    run("ss_idle", 4, 0, 0);

    // Asynchronous reset in the middle of a note
    pulse_start(2'd3);
    run("s3_load0", 1, 0, 1);
    run("s3_b", 2, 254, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_tone", int'(bus.tone_half_per), 0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_done", int'(bus.done), 0);
    chk("arst_addr", int'(bus.step_addr), 0);
    tick();
    rst = 1'b0;
    tick();
    run("post_rst", 6, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
